// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control for the MIPS pipeline. Owns the PC and decides
//   each cycle whether it advances, holds or redirects. Fetching is sequenced
//   by debug commands (run / step / stop) and pipeline events (stall, taken
//   branch, jump, HALT in IF).
//
//   Optional build macro: BRANCH_DELAY_SLOT_EN
//     defined   -> o_flush tied to 0 (delay-slot instruction is kept)
//     undefined -> wrong-path instruction in IF/ID is flushed on redirect
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_run, i_step, i_stop    debug-unit commands
//   i_stall                  hazard unit: hold PC and IF/ID
//   i_branch_taken/_target   ID-stage branch redirect
//   i_jump/_target           ID-stage jump redirect
//   i_halt_fetched           instruction in IF is HALT
//   o_pc                     registered PC (instruction memory address)
//   o_pc_plus4               o_pc + 4, wraps modulo 2^SIZE
//   o_fetch_en               IF/ID write enable
//   o_flush                  IF/ID clear (NOP insert)
//   o_state                  IDLE=0 RUN=1 STEP=2 DONE=3
//   o_cycle_count            saturating count of RUN/STEP cycles
module fetch_sequencer #(
  parameter int unsigned         SIZE     = 32,
  parameter logic [SIZE-1:0]     RESET_PC = '0,
  parameter int unsigned         CNT_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_stop,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [SIZE-1:0]     i_branch_target,
  input  logic                i_jump,
  input  logic [SIZE-1:0]     i_jump_target,
  input  logic                i_halt_fetched,
  output logic [SIZE-1:0]     o_pc,
  output logic [SIZE-1:0]     o_pc_plus4,
  output logic                o_fetch_en,
  output logic                o_flush,
  output logic [1:0]          o_state,
  output logic [CNT_SIZE-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic active;     // RUN or STEP
  logic adv;        // active and not stalled
  logic redirect;   // branch or jump wins this cycle
  logic halt_take;  // HALT is on the correct path and ends execution

  assign active    = (state == ST_RUN) || (state == ST_STEP);
  assign adv       = active && !i_stall;
  assign redirect  = i_branch_taken || i_jump;
  // A redirect alongside HALT means the HALT is wrong-path and is discarded.
  assign halt_take = adv && !redirect && i_halt_fetched;

  assign o_pc_plus4 = o_pc + SIZE'(4);
  assign o_state    = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (i_run)       state_nxt = ST_RUN;
        else if (i_step) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (halt_take)   state_nxt = ST_DONE;
        else if (i_stop) state_nxt = ST_IDLE;
      end
      // One cycle only; a stalled step still returns with the PC unchanged.
      ST_STEP: begin
        if (halt_take)   state_nxt = ST_DONE;
        else             state_nxt = ST_IDLE;
      end
      ST_DONE:           state_nxt = ST_DONE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; held low while rst is asserted.
  always_comb begin
    o_fetch_en = 1'b0;
    o_flush    = 1'b0;
    if (!rst) begin
      o_fetch_en = adv && !halt_take;
`ifdef BRANCH_DELAY_SLOT_EN
      o_flush    = 1'b0;
`else
      o_flush    = adv && redirect;
`endif
    end
  end

  // PC: stall suppresses any redirect; the hazard unit keeps it asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc <= RESET_PC;
    end else if (adv) begin
      if (i_branch_taken)      o_pc <= i_branch_target;
      else if (i_jump)         o_pc <= i_jump_target;
      else if (!i_halt_fetched) o_pc <= o_pc_plus4;
    end
  end

  // Executed-cycle counter, stalls included, saturating.
  always_ff @(posedge clk) begin
    if (rst)                          o_cycle_count <= '0;
    else if (active && !(&o_cycle_count)) o_cycle_count <= o_cycle_count + CNT_SIZE'(1);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, step, stop, stall, br, jmp, halt;
  logic [31:0] bt, jt;

  logic [31:0] pc, pc4, pc_b, pc4_b;
  logic        fe, fl, fe_b, fl_b;
  logic [1:0]  st, st_b;
  logic [31:0] cnt;
  logic [1:0]  cnt_b;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_st;
  logic [31:0] m_pc;
  longint      m_cnt;

  always #5 clk = ~clk;

  fetch_sequencer #(.SIZE(32), .RESET_PC(32'h0), .CNT_SIZE(32)) u_dut (
    .clk(clk), .rst(rst), .i_run(run), .i_step(step), .i_stop(stop),
    .i_stall(stall), .i_branch_taken(br), .i_branch_target(bt),
    .i_jump(jmp), .i_jump_target(jt), .i_halt_fetched(halt),
    .o_pc(pc), .o_pc_plus4(pc4), .o_fetch_en(fe), .o_flush(fl),
    .o_state(st), .o_cycle_count(cnt)
  );

  // Narrow counter instance for saturation checks.
  fetch_sequencer #(.SIZE(32), .RESET_PC(32'h0), .CNT_SIZE(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .i_run(run), .i_step(step), .i_stop(stop),
    .i_stall(stall), .i_branch_taken(br), .i_branch_target(bt),
    .i_jump(jmp), .i_jump_target(jt), .i_halt_fetched(halt),
    .o_pc(pc_b), .o_pc_plus4(pc4_b), .o_fetch_en(fe_b), .o_flush(fl_b),
    .o_state(st_b), .o_cycle_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_active();
    return (m_st == 1) || (m_st == 2);
  endfunction

  // Correct-path HALT: only an unstalled, non-redirected active cycle.
  function automatic bit halt_ends();
    return is_active() && !stall && !br && !jmp && halt;
  endfunction

  task automatic check_comb();
    bit exp_fe, exp_fl;
    exp_fe = !rst && is_active() && !stall && !halt_ends();
`ifdef BRANCH_DELAY_SLOT_EN
    exp_fl = 1'b0;
`else
    exp_fl = !rst && is_active() && !stall && (br || jmp);
`endif
    chk("fetch_en", 64'(fe), 64'(exp_fe));
    chk("flush", 64'(fl), 64'(exp_fl));
    chk("pc_plus4", 64'(pc4), 64'((m_pc + 32'd4) & 32'hFFFF_FFFF));
    chk("fetch_en_c2", 64'(fe_b), 64'(exp_fe));
  endtask

  task automatic check_regs();
    chk("pc", 64'(pc), 64'(m_pc));
    chk("state", 64'(st), 64'(m_st));
    chk("count", 64'(cnt), 64'(m_cnt));
    chk("count_c2", 64'(cnt_b), 64'((m_cnt > 3) ? 3 : m_cnt));
    chk("pc_c2", 64'(pc_b), 64'(m_pc));
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_clock();
    bit act, hend;
    if (rst) begin
      m_st = 0; m_pc = 32'h0; m_cnt = 0;
      return;
    end
    act  = is_active();
    hend = halt_ends();
    if (act && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (act && !stall) begin
      if (br)         m_pc = bt;
      else if (jmp)   m_pc = jt;
      else if (!halt) m_pc = m_pc + 32'd4;
    end
    case (m_st)
      0: m_st = run ? 1 : (step ? 2 : 0);
      1: m_st = hend ? 3 : (stop ? 0 : 1);
      2: m_st = hend ? 3 : 0;
      default: m_st = 3;
    endcase
  endtask

  task automatic cyc(input bit r, input bit ru, input bit sp, input bit so,
                     input bit sl, input bit b, input logic [31:0] btg,
                     input bit j, input logic [31:0] jtg, input bit h);
    @(negedge clk);
    rst = r; run = ru; step = sp; stop = so; stall = sl;
    br = b; bt = btg; jmp = j; jt = jtg; halt = h;
    #1;
    check_comb();
    @(posedge clk);
    model_clock();
    #1;
    check_regs();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1; run = 0; step = 0; stop = 0; stall = 0;
    br = 0; jmp = 0; halt = 0; bt = 0; jt = 0;
    m_st = 0; m_pc = 0; m_cnt = 0;

    // Reset, then run pulse and 4 plain RUN cycles: 0,4,8,12,16
    cyc(1, 1, 0, 0, 0, 1, 32'h55, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    repeat (4) idle_cyc();
    chk("plan_pc16", 64'(pc), 64'h10);
    chk("plan_cnt4", 64'(cnt), 64'd4);
    chk("plan_c2_sat", 64'(cnt_b), 64'd3);
    // Stop (PC still advances), then two single steps
    cyc(0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("stop_pc", 64'(pc), 64'h14);
    cyc(0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("step_state", 64'(st), 64'd2);
    idle_cyc();
    chk("step_pc", 64'(pc), 64'h18);
    chk("step_idle", 64'(st), 64'd0);
    // Run, stall with pending branch, then redirect to 0x100
    cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h100, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h100, 0, 32'h0, 0);
    chk("stall_hold", 64'(pc), 64'h18);
    cyc(0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    chk("branch_pc", 64'(pc), 64'h100);
    // Branch beats jump; jump beats HALT
    cyc(0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h40, 0);
    chk("br_over_jmp", 64'(pc), 64'h80);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h40, 1);
    chk("jmp_over_halt", 64'(pc), 64'h40);
    chk("jmp_halt_run", 64'(st), 64'd1);
    // Wrap through the top of the address space
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 0);
    idle_cyc();
    chk("wrap_fc", 64'(pc), 64'hFFFF_FFFC);
    idle_cyc();
    chk("wrap_0", 64'(pc), 64'h0);
    // HALT -> DONE, commands ignored, reset recovers
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    chk("done_state", 64'(st), 64'd3);
    cyc(0, 1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("done_pc", 64'(pc), 64'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("rst_cnt", 64'(cnt), 64'd0);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tb_t, tj_t;
      tb_t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
      tj_t = $urandom();
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0), tb_t,
          ($urandom_range(0, 7) == 0), tj_t,
          ($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
